// File: rtl/program_sequencer_pkg.sv
// Shared constants and types for the program sequencer: default geometry and
// the next-address source selector.
package program_sequencer_pkg;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    SRC_RST,
    SRC_HOLD,
    SRC_RET,
    SRC_CALL,
    SRC_JMP,
    SRC_INC
  } next_src_e;

endpackage

// File: rtl/program_sequencer_p_if.sv
// Control/status bundle between the instruction decoder (master) and the
// program sequencer (slave).
interface program_sequencer_p_if
  import program_sequencer_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic              sync_reset;
  logic              jmp;
  logic              jmp_nz;
  logic              dont_jmp;
  logic [ADDR_W-1:0] jmp_addr;
  logic              call;
  logic              ret;
  logic              stall;
  logic [ADDR_W-1:0] pm_addr;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  stack_cnt;
  logic              stack_ovf;
  logic              stack_unf;

  modport master (
    output sync_reset, jmp, jmp_nz, dont_jmp, jmp_addr, call, ret, stall,
    input  pm_addr, pc, stack_cnt, stack_ovf, stack_unf
  );

  modport slave (
    input  sync_reset, jmp, jmp_nz, dont_jmp, jmp_addr, call, ret, stall,
    output pm_addr, pc, stack_cnt, stack_ovf, stack_unf
  );

endinterface

// File: rtl/program_sequencer_stack.sv
// Return-address LIFO. Only the occupancy pointer is reset; storage is not.
module program_sequencer_stack
  import program_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_STACK_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  cnt
);

  // Storage is sized to the pointer range so every pointer value is a legal index.
  localparam int MEM_N = 1 << CNT_W;

  logic [ADDR_W-1:0] mem [MEM_N];
  logic [CNT_W-1:0]  cnt_q;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign cnt      = cnt_q;
  assign top_data = empty ? '0 : mem[cnt_q - CNT_W'(1)];

  always_ff @(posedge clk) begin
    if (push && !full) mem[cnt_q] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/program_sequencer_p.sv
// Program sequencer: prioritised next-address mux, pc register and sticky
// stack error flags around a return-address LIFO.
module program_sequencer_p
  import program_sequencer_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  program_sequencer_p_if.slave bus
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] stack_top;
  logic [ADDR_W-1:0] pm_addr;
  logic [CNT_W-1:0]  stack_cnt;
  logic              stack_full;
  logic              stack_empty;
  logic              ovf_q;
  logic              unf_q;
  logic              ovf_evt;
  logic              unf_evt;
  next_src_e         src;

  assign pc_inc = pc_q + ADDR_W'(1);

  // A refused call/ret degrades to a plain increment rather than falling
  // through to the lower-priority jump requests.
  always_comb begin
    src = SRC_INC;
    if (bus.sync_reset)                       src = SRC_RST;
    else if (bus.stall)                       src = SRC_HOLD;
    else if (bus.ret)                         src = stack_empty ? SRC_INC : SRC_RET;
    else if (bus.call)                        src = stack_full  ? SRC_INC : SRC_CALL;
    else if (bus.jmp || (bus.jmp_nz && !bus.dont_jmp)) src = SRC_JMP;
  end

  always_comb begin
    case (src)
      SRC_RST:           pm_addr = '0;
      SRC_HOLD:          pm_addr = pc_q;
      SRC_RET:           pm_addr = stack_top;
      SRC_CALL, SRC_JMP: pm_addr = bus.jmp_addr;
      default:           pm_addr = pc_inc;
    endcase
  end

  assign ovf_evt = !bus.sync_reset && !bus.stall && !bus.ret && bus.call && stack_full;
  assign unf_evt = !bus.sync_reset && !bus.stall && bus.ret && stack_empty;

  program_sequencer_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.sync_reset),
    .push      (src == SRC_CALL),
    .pop       (src == SRC_RET),
    .push_data (pc_inc),
    .top_data  (stack_top),
    .full      (stack_full),
    .empty     (stack_empty),
    .cnt       (stack_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q <= pm_addr;
      if (bus.sync_reset) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else begin
        if (ovf_evt) ovf_q <= 1'b1;
        if (unf_evt) unf_q <= 1'b1;
      end
    end
  end

  assign bus.pm_addr   = pm_addr;
  assign bus.pc        = pc_q;
  assign bus.stack_cnt = stack_cnt;
  assign bus.stack_ovf = ovf_q;
  assign bus.stack_unf = unf_q;

endmodule

// File: tb/tb_program_sequencer_p.sv
// Bench for program_sequencer_p: directed vector table, async-reset corner,
// then random control traffic against a queue-based reference model.
module tb_program_sequencer_p;

  logic clk;
  logic reset;

  program_sequencer_p_if #(.ADDR_W(8), .STACK_DEPTH(4)) bus ();

  program_sequencer_p #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         sr, stall, ret, call, jmp, jnz, dj;
    logic [7:0] addr;
    logic [7:0] e_pc, e_pm;
    int         e_cnt;
    bit         e_ovf, e_unf;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: pc, return stack as a queue, sticky flags.
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  bit         m_ovf, m_unf;

  vec_t tbl[$];

  function automatic vec_t mk(input bit sr, stall, ret, call, jmp, jnz, dj,
                              input logic [7:0] addr, e_pc, e_pm,
                              input int e_cnt, input bit e_ovf, e_unf);
    vec_t v;
    v.sr = sr; v.stall = stall; v.ret = ret; v.call = call;
    v.jmp = jmp; v.jnz = jnz; v.dj = dj; v.addr = addr;
    v.e_pc = e_pc; v.e_pm = e_pm; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] model_pm(input vec_t v);
    logic [7:0] inc;
    inc = m_pc + 8'd1;
    if (v.sr)                  return 8'h00;
    if (v.stall)               return m_pc;
    if (v.ret)                 return (m_stk.size() > 0) ? m_stk[$] : inc;
    if (v.call)                return (m_stk.size() < 4) ? v.addr : inc;
    if (v.jmp || (v.jnz && !v.dj)) return v.addr;
    return inc;
  endfunction

  task automatic model_edge(input vec_t v, input logic [7:0] pm);
    logic [7:0] inc;
    inc = m_pc + 8'd1;
    if (v.sr) begin
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!v.stall) begin
      if (v.ret) begin
        if (m_stk.size() > 0) void'(m_stk.pop_back());
        else m_unf = 1'b1;
      end else if (v.call) begin
        if (m_stk.size() < 4) m_stk.push_back(inc);
        else m_ovf = 1'b1;
      end
    end
    m_pc = pm;
  endtask

  task automatic drive(input vec_t v);
    bus.sync_reset = v.sr;
    bus.stall      = v.stall;
    bus.ret        = v.ret;
    bus.call       = v.call;
    bus.jmp        = v.jmp;
    bus.jmp_nz     = v.jnz;
    bus.dont_jmp   = v.dj;
    bus.jmp_addr   = v.addr;
  endtask

  task automatic model_reset();
    m_pc = 8'h00;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive at the falling edge, check 1ns later, advance the model at the rising edge.
  task automatic step(input vec_t v, input bit from_tbl, input string tag);
    logic [7:0] pm;
    drive(v);
    #1;
    pm = model_pm(v);
    if (from_tbl) begin
      chk({tag, "_pm"},  bus.pm_addr,   v.e_pm);
      chk({tag, "_pc"},  bus.pc,        v.e_pc);
      chk({tag, "_cnt"}, bus.stack_cnt, v.e_cnt);
      chk({tag, "_ovf"}, bus.stack_ovf, v.e_ovf);
      chk({tag, "_unf"}, bus.stack_unf, v.e_unf);
    end else begin
      chk({tag, "_pm"},  bus.pm_addr,   pm);
      chk({tag, "_pc"},  bus.pc,        m_pc);
      chk({tag, "_cnt"}, bus.stack_cnt, m_stk.size());
      chk({tag, "_ovf"}, bus.stack_ovf, m_ovf);
      chk({tag, "_unf"}, bus.stack_unf, m_unf);
    end
    @(posedge clk);
    model_edge(v, pm);
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    vec_t idle_v;
    idle_v = mk(0,0,0,0,0,0,0, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    //            sr st rt cl jp jn dj addr   e_pc   e_pm  cnt ovf unf
    tbl.push_back(mk(0,0,0,0,0,0,0, 8'h00, 8'h00, 8'h01, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 8'h00, 8'h01, 8'h02, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 8'h00, 8'h02, 8'h03, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 8'h00, 8'h03, 8'h04, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 8'h00, 8'h04, 8'h05, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,0, 8'h10, 8'h05, 8'h10, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,1, 8'h40, 8'h10, 8'h11, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,0, 8'h10, 8'h11, 8'h10, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0, 8'h40, 8'h10, 8'h40, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,0, 8'h05, 8'h40, 8'h05, 0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0, 8'h80, 8'h05, 8'h80, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 8'h00, 8'h80, 8'h81, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 8'h00, 8'h81, 8'h82, 1,0,0));
    tbl.push_back(mk(0,0,1,0,0,0,0, 8'h00, 8'h82, 8'h06, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 8'h00, 8'h06, 8'h07, 0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0, 8'h20, 8'h07, 8'h20, 0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0, 8'h30, 8'h20, 8'h30, 1,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0, 8'h40, 8'h30, 8'h40, 2,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0, 8'h50, 8'h40, 8'h50, 3,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0, 8'h60, 8'h50, 8'h51, 4,0,0));
    tbl.push_back(mk(0,0,1,0,0,0,0, 8'h00, 8'h51, 8'h41, 4,1,0));
    tbl.push_back(mk(0,0,1,0,0,0,0, 8'h00, 8'h41, 8'h31, 3,1,0));
    tbl.push_back(mk(0,0,1,0,0,0,0, 8'h00, 8'h31, 8'h21, 2,1,0));
    tbl.push_back(mk(0,0,1,0,0,0,0, 8'h00, 8'h21, 8'h08, 1,1,0));
    tbl.push_back(mk(0,0,1,0,0,0,0, 8'h00, 8'h08, 8'h09, 0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 8'h00, 8'h09, 8'h0A, 0,1,1));
    tbl.push_back(mk(1,0,0,0,0,0,0, 8'h00, 8'h0A, 8'h00, 0,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 8'h00, 8'h00, 8'h01, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,0, 8'hFE, 8'h01, 8'hFE, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 8'h00, 8'hFE, 8'hFF, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 8'h00, 8'hFF, 8'h00, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,0, 8'hFF, 8'h00, 8'hFF, 0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0, 8'h10, 8'hFF, 8'h10, 0,0,0));
    tbl.push_back(mk(0,0,1,0,0,0,0, 8'h00, 8'h10, 8'h00, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 8'h00, 8'h00, 8'h01, 0,0,0));
    tbl.push_back(mk(0,0,1,1,0,0,0, 8'h33, 8'h01, 8'h02, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 8'h00, 8'h02, 8'h03, 0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0, 8'h00, 8'h03, 8'h00, 0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 8'h00, 8'h00, 8'h01, 0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0, 8'h77, 8'h01, 8'h01, 0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0, 8'h77, 8'h01, 8'h01, 0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0, 8'h77, 8'h01, 8'h01, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 8'h00, 8'h01, 8'h02, 0,0,0));
    tbl.push_back(mk(1,1,0,1,1,0,0, 8'h55, 8'h02, 8'h00, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 8'h00, 8'h00, 8'h01, 0,0,0));

    // Reset state, held across clock edges.
    reset = 1'b1;
    drive(idle_v);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc",  bus.pc,        0);
    chk("rst_cnt", bus.stack_cnt, 0);
    chk("rst_ovf", bus.stack_ovf, 0);
    chk("rst_unf", bus.stack_unf, 0);
    chk("rst_pm",  bus.pm_addr,   1);
    reset = 1'b0;
    model_reset();

    foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("tbl%0d", i));

    // Async reset mid-cycle with a call in flight: must clear before the edge
    // and discard the push at the edge it spans.
    for (int i = 0; i < 5; i++) begin
      v = mk(0,0,0,1,0,0,0, 8'h50 + 8'(i), 8'h00, 8'h00, 0,0,0);
      step(v, 1'b0, $sformatf("pre_ar%0d", i));
    end
    v = mk(0,0,0,1,0,0,0, 8'h99, 8'h00, 8'h00, 0,0,0);
    drive(v);
    #2 reset = 1'b1;
    #1;
    chk("ar_pc",  bus.pc,        0);
    chk("ar_cnt", bus.stack_cnt, 0);
    chk("ar_ovf", bus.stack_ovf, 0);
    chk("ar_unf", bus.stack_unf, 0);
    chk("ar_pm",  bus.pm_addr,   8'h99);
    @(posedge clk);
    #1;
    chk("ar_edge_cnt", bus.stack_cnt, 0);
    chk("ar_edge_pc",  bus.pc,        0);
    @(negedge clk);
    drive(idle_v);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) step(idle_v, 1'b0, $sformatf("post_ar%0d", i));

    // Random control traffic.
    for (int i = 0; i < 400; i++) begin
      v.sr    = ($urandom_range(0, 39) == 0);
      v.stall = ($urandom_range(0, 7) == 0);
      v.ret   = ($urandom_range(0, 4) == 0);
      v.call  = ($urandom_range(0, 3) == 0);
      v.jmp   = ($urandom_range(0, 9) == 0);
      v.jnz   = ($urandom_range(0, 3) == 0);
      v.dj    = 1'($urandom_range(0, 1));
      v.addr  = 8'($urandom_range(0, 255));
      step(v, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
